// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, halt opcode and instruction field positions for the fetch unit
package inst_fetch_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 25;

    localparam logic [4:0] OPC_HALT = 5'b11111;

    // Instruction word layout
    localparam int OPC_MSB  = 24;
    localparam int OPC_LSB  = 20;
    localparam int DEST_MSB = 19;
    localparam int DEST_LSB = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 12;
    localparam int SRC2_MSB = 11;
    localparam int SRC2_LSB = 8;
    localparam int IMM_MSB  = 7;
    localparam int IMM_LSB  = 0;

endpackage

// File: rtl/fetch_fifo2.sv
// rtl/fetch_fifo2.sv - two-entry FIFO with same-cycle push/pop and flush
module fetch_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] data_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    logic [1:0]   cnt_q, cnt_d;
    logic [W-1:0] e0_q, e0_d;
    logic [W-1:0] e1_q, e1_d;
    logic         pop_ok, push_ok;

    // Next-state: pop shifts entry1 down first, then push lands in the first free slot
    always_comb begin
        cnt_d   = cnt_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        pop_ok  = pop_i && (cnt_q != 2'd0);
        push_ok = push_i && ((cnt_q != 2'd2) || pop_ok);
        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            if (pop_ok) begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            if (push_ok) begin
                if (cnt_d == 2'd0) begin
                    e0_d = data_i;
                end else begin
                    e1_d = data_i;
                end
                cnt_d = cnt_d + 2'd1;
            end
        end
    end

    // Storage registers; reset clears entries so the head reads as zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = e0_q;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch unit with redirect, halt detection and 2-entry decode buffer
module inst_fetch #(
    parameter int ADDR_W = inst_fetch_pkg::ADDR_W,
    parameter int INST_W = inst_fetch_pkg::INST_W
) (
    input  logic              clk,
    input  logic              reset,
    output logic              instRead,
    output logic [ADDR_W-1:0] address,
    input  logic [INST_W-1:0] mem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [ADDR_W-1:0] out_pc,
    output logic              halted
);
    import inst_fetch_pkg::*;

    localparam int ENT_W = ADDR_W + INST_W;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tag_q, tag_d;
    logic              inflight_q, inflight_d;
    logic              halted_q, halted_d;

    logic [1:0]        count;
    logic [ENT_W-1:0]  head;
    logic              pop, push;
    logic [2:0]        occupancy;

    // Handshake, issue and enqueue decisions; redirect overrides everything
    always_comb begin
        pop       = out_valid && out_ready && !redirect_valid;
        occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
        instRead  = !reset && !halted_q && !redirect_valid && (occupancy <= 3'd1);
        push      = inflight_q && !redirect_valid && !halted_q;
    end

    // Next pc / inflight tag / halt flag
    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        halted_d   = halted_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
        end else begin
            if (push && (mem_data[OPC_MSB:OPC_LSB] == OPC_HALT)) begin
                halted_d = 1'b1;
            end
            if (instRead) begin
                pc_d       = pc_q + ADDR_W'(1);
                tag_d      = pc_q;
                inflight_d = 1'b1;
            end
        end
    end

    // Fetch state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= '0;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
        end
    end

    fetch_fifo2 #(.W(ENT_W)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .data_i  ({tag_q, mem_data}),
        .count_o (count),
        .head_o  (head)
    );

    assign address   = pc_q;
    assign halted    = halted_q;
    assign out_valid = (count != 2'd0);
    assign out_pc    = head[ENT_W-1:INST_W];
    assign out_inst  = head[INST_W-1:0];

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - self-checking bench for inst_fetch against a queue-based reference model
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        instRead;
    logic [7:0]  address;
    logic [24:0] mem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] out_inst;
    logic [7:0]  out_pc;
    logic        halted;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .instRead       (instRead),
        .address        (address),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    logic [24:0] mem [256];

    // Synchronous instruction memory: data returns the cycle after the read strobe
    always @(posedge clk) begin
        if (instRead) mem_data <= mem[address];
    end

    // Reference model state
    logic [7:0]  m_pc, m_tag;
    bit          m_infl, m_halt;
    logic [32:0] fq[$];
    logic [7:0]  obs_q[$];
    int          iss_cnt;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit rst, input bit rdy, input bit rv, input logic [7:0] rpc);
        bit mv, pop, iss;
        reset          = rst;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #2;
        mv  = fq.size() > 0;
        pop = mv && rdy && !rv;
        iss = !rst && !m_halt && !rv && ((fq.size() + int'(m_infl) - int'(pop)) <= 1);
        chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
        if (mv) begin
            chk("out_pc", {24'd0, out_pc}, {24'd0, fq[0][32:25]});
            chk("out_inst", {7'd0, out_inst}, {7'd0, fq[0][24:0]});
        end
        chk("instRead", {31'd0, instRead}, {31'd0, iss});
        chk("address", {24'd0, address}, {24'd0, m_pc});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        if (out_valid && rdy && !rv && !rst) obs_q.push_back(out_pc);
        if (instRead === 1'b1) iss_cnt++;
        @(posedge clk);
        #1;
        if (rst) begin
            fq.delete();
            m_pc = 8'd0; m_tag = 8'd0; m_infl = 1'b0; m_halt = 1'b0;
        end else if (rv) begin
            fq.delete();
            m_pc = rpc; m_infl = 1'b0; m_halt = 1'b0;
        end else begin
            if (pop) void'(fq.pop_front());
            if (m_infl && !m_halt) begin
                fq.push_back({m_tag, mem[m_tag]});
                if (mem[m_tag][24:20] == OPC_HALT) m_halt = 1'b1;
            end
            if (iss) begin
                m_tag  = m_pc;
                m_pc   = m_pc + 8'd1;
                m_infl = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, rdy, 1'b0, 8'h00);
    endtask

    task automatic check_seq(input string tag, input logic [7:0] first, input int len);
        chk({tag, "_len"}, obs_q.size(), len);
        for (int i = 0; i < obs_q.size() && i < len; i++)
            chk(tag, {24'd0, obs_q[i]}, {24'd0, first + 8'(i)});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 25'($urandom);
            if (mem[i][24:20] == OPC_HALT) mem[i][24:20] = 5'd0;
        end
        reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        fq.delete(); m_pc = 0; m_tag = 0; m_infl = 0; m_halt = 0;
        @(posedge clk);
        #1;
        chk("rst_out_inst", {7'd0, out_inst}, 32'd0);
        chk("rst_out_pc", {24'd0, out_pc}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);

        // Streaming from reset with decode always ready
        obs_q.delete();
        run(8, 1'b1);
        check_seq("stream", 8'h00, 6);

        // Decode stalled right after reset: only two fetches may be issued
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        obs_q.delete();
        iss_cnt = 0;
        run(5, 1'b0);
        chk("stall_issues", iss_cnt, 2);
        run(6, 1'b1);
        check_seq("stall_resume", 8'h00, 6);

        // Redirect with a full buffer
        run(3, 1'b0);
        obs_q.delete();
        cyc(1'b0, 1'b1, 1'b1, 8'h40);
        run(6, 1'b1);
        check_seq("redirect", 8'h40, 4);

        // Address wrap
        obs_q.delete();
        cyc(1'b0, 1'b1, 1'b1, 8'hFF);
        run(6, 1'b1);
        check_seq("wrap", 8'hFF, 4);

        // Reset with the buffer holding two entries
        run(3, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst_full_valid", {31'd0, out_valid}, 32'd0);
        obs_q.delete();
        run(6, 1'b1);
        check_seq("rst_refetch", 8'h00, 4);

        // Halt at address 3, then resume by redirect
        reset = 1'b1;
        mem[3][24:20] = OPC_HALT;
        cyc(1'b1, 1'b1, 1'b0, 8'h00);
        obs_q.delete();
        run(12, 1'b1);
        check_seq("halt", 8'h00, 4);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        iss_cnt = 0;
        run(4, 1'b1);
        chk("halt_no_issue", iss_cnt, 0);
        obs_q.delete();
        cyc(1'b0, 1'b1, 1'b1, 8'h00);
        run(8, 1'b1);
        check_seq("resume", 8'h00, 4);

        // Randomized traffic with sporadic halts, redirects and resets
        reset = 1'b1;
        for (int i = 0; i < 256; i++)
            if (($urandom % 100) < 4) mem[i][24:20] = OPC_HALT;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 150) == 0, ($urandom % 100) < 70,
                ($urandom % 100) < 6, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
